// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants and period lookup for the real-time clock tick source
package rtc_pkg;

  localparam logic [3:0] RTC_SEL_RESET = 4'd11;
  localparam int         RTC_PMAX      = 800;

  // Period in milliseconds for each panel select code; unused codes fall back to 10 ms.
  function automatic logic [9:0] rtc_period(input logic [3:0] sel);
    logic [9:0] p;
    case (sel)
      4'd0:    p = 10'd2;
      4'd1:    p = 10'd4;
      4'd2:    p = 10'd8;
      4'd3:    p = 10'd10;
      4'd4:    p = 10'd20;
      4'd5:    p = 10'd40;
      4'd6:    p = 10'd80;
      4'd7:    p = 10'd100;
      4'd8:    p = 10'd200;
      4'd9:    p = 10'd400;
      4'd10:   p = 10'd800;
      default: p = 10'd10;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchroniser for asynchronous panel inputs
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rtc_tick.sv
// rtl/rtc_tick.sv - programmable-period timer interrupt pulse (zegar) with manual single-step
module rtc_tick
  import rtc_pkg::*;
#(
  parameter int MS_DIV      = 50000,
  parameter int PULSE_TICKS = 4
) (
  input  logic       clk_sys,
  input  logic       clm,
  input  logic       en_a,
  input  logic [3:0] sel_a,
  input  logic       step_a,
  output logic       zegar,
  output logic       ms_tick
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int WW = $clog2(PULSE_TICKS + 1);
  localparam int MW = $clog2(RTC_PMAX);

  localparam logic [PW-1:0] PCNT_TERM  = PW'(MS_DIV - 1);
  localparam logic [WW-1:0] PULSE_LOAD = WW'(PULSE_TICKS);

  logic       en_s;
  logic [3:0] sel_s;
  logic       step_s;

  logic          step_q;
  logic [3:0]    sel_q;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          zegar_q;

  logic          sel_chg;
  logic          ms_tick_c;
  logic [MW-1:0] period_last;
  logic          per_fire;
  logic          step_fire;
  logic          fire;

  sync2 #(.WIDTH(1)) u_sync_en (
    .clk_i (clk_sys),
    .rst_i (clm),
    .d_i   (en_a),
    .q_o   (en_s)
  );

  sync2 #(.WIDTH(4)) u_sync_sel (
    .clk_i (clk_sys),
    .rst_i (clm),
    .d_i   (sel_a),
    .q_o   (sel_s)
  );

  sync2 #(.WIDTH(1)) u_sync_step (
    .clk_i (clk_sys),
    .rst_i (clm),
    .d_i   (step_a),
    .q_o   (step_s)
  );

  always_comb begin
    sel_chg     = (sel_s != sel_q);
    ms_tick_c   = en_s && (pcnt_q == PCNT_TERM);
    period_last = MW'(rtc_period(sel_q) - 10'd1);
    // A period change restarts counting, so a coinciding terminal count must not fire.
    per_fire    = ms_tick_c && (mcnt_q == period_last) && !sel_chg;
    step_fire   = step_s && !step_q;
    fire        = per_fire || step_fire;

    pcnt_d = pcnt_q;
    mcnt_d = mcnt_q;
    if (!en_s || sel_chg) begin
      pcnt_d = '0;
      mcnt_d = '0;
    end else begin
      pcnt_d = (pcnt_q == PCNT_TERM) ? '0 : pcnt_q + 1'b1;
      if (ms_tick_c) begin
        mcnt_d = (mcnt_q == period_last) ? '0 : mcnt_q + 1'b1;
      end
    end

    // Reload rather than restart: overlapping fires stretch one pulse instead of making two edges.
    if (fire) begin
      wcnt_d = PULSE_LOAD;
    end else if (wcnt_q != '0) begin
      wcnt_d = wcnt_q - 1'b1;
    end else begin
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (clm) begin
      step_q  <= 1'b0;
      sel_q   <= RTC_SEL_RESET;
      pcnt_q  <= '0;
      mcnt_q  <= '0;
      wcnt_q  <= '0;
      zegar_q <= 1'b0;
    end else begin
      step_q  <= step_s;
      sel_q   <= sel_s;
      pcnt_q  <= pcnt_d;
      mcnt_q  <= mcnt_d;
      wcnt_q  <= wcnt_d;
      zegar_q <= (wcnt_d != '0);
    end
  end

  assign zegar   = zegar_q;
  assign ms_tick = ms_tick_c;

endmodule

// File: tb/tb_rtc_tick.sv
// tb/tb_rtc_tick.sv - directed checks of rtc_tick with MS_DIV=4, PULSE_TICKS=3
module tb_rtc_tick;

  logic       clk_sys = 1'b0;
  logic       clm     = 1'b1;
  logic       en_a    = 1'b1;
  logic [3:0] sel_a   = 4'd11;
  logic       step_a  = 1'b0;
  logic       zegar;
  logic       ms_tick;

  int vec_cnt = 0;
  int err_cnt = 0;

  rtc_tick #(
    .MS_DIV      (4),
    .PULSE_TICKS (3)
  ) dut (
    .clk_sys (clk_sys),
    .clm     (clm),
    .en_a    (en_a),
    .sel_a   (sel_a),
    .step_a  (step_a),
    .zegar   (zegar),
    .ms_tick (ms_tick)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic obs, input logic exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s[%0d] observed=%0b expected=%0b", tag, idx, obs, exp);
    end
  endtask

  initial begin
    // Reset held 5 cycles with the enable switch on.
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("rst_zegar", i, zegar, 1'b0);
      check("rst_ms_tick", i, ms_tick, 1'b0);
    end
    clm = 1'b0;

    // sel sync leaves reset at 0, so one sel-change clear lands at cycle 2; clean counting from cycle 3.
    for (int n = 1; n <= 46; n++) begin
      tick();
      check("boot_zegar", n, zegar, (n >= 43 && n <= 45));
      check("boot_ms_tick", n, ms_tick, (n >= 6 && (n - 6) % 4 == 0));
    end

    // Cadence at 2 ms: 3 high every 8 cycles, ms_tick every 4.
    sel_a = 4'd0;
    for (int m = 1; m <= 94; m++) begin
      tick();
      check("cad_zegar", m, zegar, (m >= 11 && ((m - 11) % 8) < 3));
      check("cad_ms_tick", m, ms_tick, (m >= 6 && (m - 6) % 4 == 0));
    end

    // 4 ms period, then back to 2 ms after two ms_ticks; disable right after the next rise.
    sel_a = 4'd1;
    for (int j = 1; j <= 22; j++) begin
      tick();
      check("chg_zegar", j, zegar, (j >= 21 && j <= 22));
      check("chg_ms_tick", j, ms_tick, (j == 6 || j == 10 || j == 16 || j == 20));
      if (j == 10) sel_a = 4'd0;
      if (j == 22) en_a = 1'b0;
    end

    for (int i = 1; i <= 101; i++) begin
      tick();
      check("dis_zegar", i, zegar, (i == 1));
      check("dis_ms_tick", i, ms_tick, 1'b0);
    end

    // Manual step while disabled, held high.
    step_a = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      check("step_zegar", i, zegar, (i >= 3 && i <= 5));
      check("step_ms_tick", i, ms_tick, 1'b0);
    end
    step_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("step_rel_zegar", i, zegar, 1'b0);
    end

    // Re-enable; step edge reaches the core one cycle before the period fire.
    en_a = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      tick();
      check("ovl_zegar", i, zegar, ((i >= 9 && i <= 12) || (i >= 18 && i <= 19)));
      check("ovl_ms_tick", i, ms_tick, (i == 5 || i == 9 || i == 13 || i == 17));
      if (i == 6) step_a = 1'b1;
    end

    // Master clear mid-pulse drops zegar on the next cycle.
    clm = 1'b1;
    tick();
    check("clm_zegar", 0, zegar, 1'b0);
    check("clm_ms_tick", 0, ms_tick, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rtc_tick.md
# rtc_tick

Real-time clock interrupt source for the CPU interrupt system. It divides `clk_sys` down to a programmable period selected from the control panel. On each elapsed period it drives a fixed-width `zegar` pulse into the interrupt-request register, at interrupt line 5 (timer). It also supports a manual single-tick from the panel and restarts cleanly on any period change.

## Interface
Parameters:
- `MS_DIV`, 50000: `clk_sys` cycles per millisecond; 2 minimum; benches use small values.
- `PULSE_TICKS`, 4: width of a `zegar` pulse in cycles; 1 minimum; must be less than 2×`MS_DIV`.

Ports:
- `clk_sys`, in, 1: system clock.
- `clm`, in, 1: master clear. One clock; reset is synchronous and active-high.
- `en_a`, in, 1: clock enable panel switch; asynchronous.
- `sel_a`, in, 4: period select panel switches; asynchronous.
- `step_a`, in, 1: manual tick button; asynchronous; already debounced.
- `zegar`, out, 1: timer interrupt request pulse.
- `ms_tick`, out, 1: one-cycle strobe per elapsed millisecond; for diagnostics only.

## Operation
- Synchronisation:
  - `en_a`, `sel_a` and `step_a` each pass through 2-flop synchronisers, giving `en`, `sel` and `step`.
  - All logic below uses only the synchronised values.
- Period table, `sel` to P in ms: 0=2, 1=4, 2=8, 3=10, 4=20, 5=40, 6=80, 7=100, 8=200, 9=400, 10=800, 11..15=10.
- Prescaler `pcnt`:
  - Width is clog2(`MS_DIV`).
  - Counts 0..`MS_DIV`-1 while `en`=1.
  - At the terminal value it wraps to 0 and asserts `ms_tick` for that cycle.
- Period counter `mcnt`:
  - 10 bits wide.
  - Increments on `ms_tick`.
  - When `ms_tick` occurs with `mcnt`=P-1, it wraps to 0 and raises the fire request.
- Pulse generator:
  - `wcnt` is loaded with `PULSE_TICKS` on any fire request.
  - `zegar`=1 whenever `wcnt`≠0; `wcnt` decrements every cycle.
  - A fire request during an active pulse reloads `wcnt`. The pulse extends; no second edge is produced.
- Manual step:
  - A rising edge of `step` (registered compare) raises a fire request.
  - It does so regardless of `en`.
  - It does not disturb `pcnt` or `mcnt`.
- Enable low:
  - `pcnt` and `mcnt` are held at 0 and `ms_tick`=0.
  - An in-flight `zegar` pulse completes normally.
- Period change:
  - A registered copy `sel_q` is compared against `sel`.
  - On mismatch, `pcnt` and `mcnt` clear to 0 in that cycle and `sel_q` updates.
  - No fire request occurs in that cycle, even if it coincides with a terminal count.
- Simultaneous events:
  - Period change plus a step edge: the step fire still occurs.
  - `ms_tick` terminal plus a step edge: a single reload occurs.

## Timing
- Reset values: `zegar`=0, `ms_tick`=0, `pcnt`=`mcnt`=`wcnt`=0.
  - `sel_q`=10 ms encoding (11), synchroniser flops=0, step edge register=0.
- `clm` mid-pulse: `zegar` drops the next cycle. Counting restarts once `clm` falls and `en`=1.
- Input latency:
  - Asynchronous input change to synchronised value: 2 cycles.
  - Step edge to `zegar` high: 3 cycles after `step_a` rises (2 sync + edge register; `zegar` is registered).
- Period cadence:
  - Counting starts on the first cycle with `en`=1 and `pcnt`=0.
  - `zegar` rises P×`MS_DIV` cycles later, then every P×`MS_DIV` cycles while `en` and `sel` are stable.
  - Each rise is exactly `PULSE_TICKS` cycles wide.
- `ms_tick` is combinational from `pcnt` terminal and `en`. `zegar` is a flop output.

## Structure
- Package `rtc_pkg`:
  - Function `rtc_period(sel)` returning 10-bit P.
  - Constant `RTC_SEL_RESET`=4'd11.
  - Constant `RTC_PMAX`=800.
- Sub-module `sync2`: generic 2-flop synchroniser with WIDTH parameter and reset, instanced for `en`, `sel` and `step`.

## Test plan
All scenarios use `MS_DIV`=4 and `PULSE_TICKS`=3.
- Reset: `clm`=1 for 5 cycles with `en_a`=1 → `zegar`=0 and `ms_tick`=0 throughout. With `sel_a`=11 and `en_a` held at 1, the first `zegar` rise comes 40 cycles after the first counting cycle.
- Cadence: `sel_a`=0, `en_a`=1 → `zegar` high for 3 cycles every 8 cycles. `ms_tick` fires every 4 cycles; 10 periods are checked.
- Period change: after 2 `ms_tick`s with `sel`=1, switch `sel_a` to 0 → counters clear on the mismatch cycle. The next `zegar` rise is exactly 8 cycles after the clear, with no spurious pulse.
- Disable mid-pulse: drop `en_a` one cycle after `zegar` rises → the pulse completes its full 3 cycles. No further pulses occur for 100 cycles and `ms_tick` stays 0.
- Manual step with `en_a`=0: `step_a` rises → `zegar` high 3 cycles later, for 3 cycles. Holding `step_a` high produces no second pulse.
- Overlap: step edge lands 1 cycle before a period fire (`sel`=0) → a single merged `zegar` high of 4 cycles (3 + reload). It is never split into two edges.
